// File: rtl/xswitch_pkg.sv
// Shared definitions for the xswitch port feeders, the switch itself and its benches.
package xswitch_pkg;

  localparam int XSW_DATA_W = 8;
  localparam int XSW_ADDR_W = 2;

  typedef struct packed {
    logic [XSW_ADDR_W-1:0] addr;
    logic [XSW_DATA_W-1:0] data;
  } xsw_word_t;

  typedef enum logic [0:0] {
    TX_EMPTY   = 1'b0,
    TX_PRESENT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/xswitch_tx_fifo.sv
// DEPTH-entry first-word-fall-through FIFO: rd_data always shows the oldest entry.
module xswitch_tx_fifo
  import xswitch_pkg::*;
#(
  parameter int W     = XSW_ADDR_W + XSW_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xswitch_port_tx.sv
// Transmit feeder for one xswitch input port: buffers producer words and presents
// them on a valid_in/rcv_rdy handshake, with a sent-word counter and stall watchdog.
module xswitch_port_tx
  import xswitch_pkg::*;
#(
  parameter int DATA_W    = XSW_DATA_W,
  parameter int ADDR_W    = XSW_ADDR_W,
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_in,
  output logic              valid_in,
  input  logic              rcv_rdy,
  output logic [15:0]       sent_cnt,
  output logic              stall_err,
  input  logic              err_clr,
  output logic              tx_state
);

  // Handshake: a word moves when valid/ready are both high at a rising edge.
  // valid_in, once high, holds with stable data until rcv_rdy takes the word.
  localparam int W  = ADDR_W + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [0:0]    S_EMPTY   = 1'(TX_EMPTY);
  localparam logic [0:0]    S_PRESENT = 1'(TX_PRESENT);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);
  localparam logic [SW-1:0] STALL_PRE = SW'(STALL_MAX - 1);

  logic [0:0]    state_q, state_d;
  logic [15:0]   sent_q, sent_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
  logic          stall_set;

  logic [W-1:0]  head_word;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push_fire, xfer;

  // push_ready depends on the stored count only, never on rcv_rdy.
  assign push_ready = !fifo_full;
  assign push_fire  = push_valid && push_ready;
  assign valid_in   = (state_q == S_PRESENT);
  assign xfer       = valid_in && rcv_rdy;
  assign {addr_in, data_in} = valid_in ? head_word : '0;

  assign sent_cnt  = sent_q;
  assign stall_err = err_q;
  assign tx_state  = state_q;

  xswitch_tx_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push_fire),
    .wr_data ({push_addr, push_data}),
    .rd_en   (xfer),
    .rd_data (head_word),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:   if (push_fire || !fifo_empty) state_d = S_PRESENT;
      S_PRESENT: if (xfer && !push_fire && fifo_count == CNT_ONE) state_d = S_EMPTY;
      default:   state_d = S_EMPTY;
    endcase
  end

  // Watchdog flags only the cycle the run reaches the limit; a saturated run cannot re-set it.
  always_comb begin
    stall_d   = stall_q;
    stall_set = 1'b0;
    if (!valid_in || xfer) begin
      stall_d = '0;
    end else if (stall_q != STALL_LIM) begin
      stall_d = stall_q + 1'b1;
      if (stall_q == STALL_PRE) stall_set = 1'b1;
    end
    err_d = stall_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    sent_d = xfer ? sent_q + 16'd1 : sent_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      sent_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_xswitch_port_tx.sv
// Directed bench for xswitch_port_tx with a word scoreboard on the switch side.
module tb_xswitch_port_tx;
  import xswitch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [7:0] push_data = '0;
  logic [1:0] push_addr = '0;
  logic [7:0] data_in;
  logic [1:0] addr_in;
  logic       valid_in;
  logic       rcv_rdy = 1'b0;
  logic [15:0] sent_cnt;
  logic       stall_err;
  logic       err_clr = 1'b0;
  logic       tx_state;

  int nvec  = 0;
  int nfail = 0;
  logic [9:0] exp_q[$];

  xswitch_port_tx #(
    .DATA_W    (8),
    .ADDR_W    (2),
    .DEPTH     (4),
    .STALL_MAX (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .push_addr  (push_addr),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .valid_in   (valid_in),
    .rcv_rdy    (rcv_rdy),
    .sent_cnt   (sent_cnt),
    .stall_err  (stall_err),
    .err_clr    (err_clr),
    .tx_state   (tx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    push_valid = 1'b0;
    rcv_rdy = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    nvec++;
    assert (exp_q.size() == 0) else begin
      nfail++;
      $error("FAIL drain: observed %0d words pending expected 0", exp_q.size());
    end
  endtask

  // scoreboard: inputs change just after posedge, so negedge sees what the next edge commits
  always @(negedge clk) begin
    logic [9:0] w;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (valid_in && rcv_rdy) begin
        nvec++;
        assert (exp_q.size() > 0) else begin
          nfail++;
          $error("FAIL xfer_unexpected: observed %0h expected no transfer", {addr_in, data_in});
        end
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("xfer_word", {22'd0, addr_in, data_in}, {22'd0, w});
        end
      end
      if (push_valid && push_ready) exp_q.push_back({push_addr, push_data});
    end
  end

  initial begin
    xsw_word_t wd;

    // reset state
    #1;
    check("rst_valid", valid_in, 1'b0);
    check("rst_data", data_in, 8'h00);
    check("rst_addr", addr_in, 2'd0);
    check("rst_ready", push_ready, 1'b1);
    check("rst_sent", sent_cnt, 16'd0);
    check("rst_err", stall_err, 1'b0);
    check("rst_state", tx_state, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // single word, one-cycle latency, valid for exactly one cycle
    rcv_rdy = 1'b1;
    wd.addr = 2'd2;
    wd.data = 8'hA5;
    push_addr = wd.addr;
    push_data = wd.data;
    push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    check("single_valid", valid_in, 1'b1);
    check("single_data", data_in, 8'hA5);
    check("single_addr", addr_in, 2'd2);
    tick();
    check("single_drop", valid_in, 1'b0);
    check("single_sent", sent_cnt, 16'd1);

    // backpressure: fill, refuse while full (even alongside a transfer), then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push_valid = 1'b1;
      push_data = 8'(i);
      push_addr = 2'(i);
      check("bp_ready_fill", push_ready, 1'b1);
      tick();
    end
    push_data = 8'h05;
    push_addr = 2'd1;
    check("bp_full", push_ready, 1'b0);
    check("bp_hold_valid", valid_in, 1'b1);
    check("bp_hold_data", data_in, 8'h01);
    tick();
    check("bp_full2", push_ready, 1'b0);
    check("bp_hold_data2", data_in, 8'h01);
    rcv_rdy = 1'b1;
    tick();
    push_valid = 1'b0;
    check("bp_refused", push_ready, 1'b1);
    check("bp_d2", data_in, 8'h02);
    tick();
    check("bp_d3", data_in, 8'h03);
    tick();
    check("bp_d4", data_in, 8'h04);
    check("bp_v4", valid_in, 1'b1);
    tick();
    check("bp_empty", valid_in, 1'b0);
    check("bp_sent", sent_cnt, 16'd4);
    for (int i = 5; i <= 6; i++) begin
      push_valid = 1'b1;
      push_data = 8'(i);
      push_addr = 2'(i);
      tick();
    end
    push_valid = 1'b0;
    drain();

    // streaming: no bubbles
    do_reset();
    rcv_rdy = 1'b1;
    push_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      push_data = 8'(8'h10 + k - 1);
      push_addr = 2'(k);
      tick();
      check("stream_valid", valid_in, 1'b1);
      check("stream_data", data_in, 8'(8'h10 + k - 1));
    end
    push_valid = 1'b0;
    tick();
    check("stream_idle", valid_in, 1'b0);
    check("stream_sent", sent_cnt, 16'd16);

    // watchdog
    do_reset();
    push_data = 8'h3C;
    push_addr = 2'd1;
    push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("wd_before", stall_err, 1'b0);
    tick();
    check("wd_set", stall_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_clr", stall_err, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("wd_no_reset", stall_err, 1'b0);
    check("wd_still_valid", valid_in, 1'b1);
    check("wd_still_data", data_in, 8'h3C);
    rcv_rdy = 1'b1;
    tick();
    check("wd_done", valid_in, 1'b0);
    check("wd_sent", sent_cnt, 16'd1);

    // reset mid-operation
    rcv_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_data = 8'(8'h40 + i);
      tick();
    end
    push_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mr_valid", valid_in, 1'b0);
    check("mr_ready", push_ready, 1'b1);
    check("mr_sent", sent_cnt, 16'd0);
    tick();
    reset = 1'b1;
    rcv_rdy = 1'b1;
    push_data = 8'h77;
    push_addr = 2'd3;
    push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    check("mr_first", data_in, 8'h77);
    tick();
    check("mr_idle", valid_in, 1'b0);
    check("mr_sent1", sent_cnt, 16'd1);
    drain();

    // sent_cnt wrap
    do_reset();
    rcv_rdy = 1'b1;
    push_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      push_data = 8'(i);
      push_addr = 2'(i >> 8);
      tick();
    end
    push_valid = 1'b0;
    tick();
    check("wrap_sent", sent_cnt, 16'd1);
    check("wrap_idle", valid_in, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
